// File: rtl/pwm_cfg_pkg.sv
// pwm_cfg_pkg: register map, frame geometry and FSM states for the SPI PWM config controller
package pwm_cfg_pkg;
  localparam int NUM_REGS    = 5;
  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int FRAME_BITS  = 16;
  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
endpackage

// File: rtl/spi_pwm_cfg_ctrl_if.sv
// spi_pwm_cfg_ctrl_if: SPI pin bundle between the bus master and the config controller
interface spi_pwm_cfg_ctrl_if;
  logic sclk;
  logic copi;
  logic ncs;
  modport master (output sclk, copi, ncs);
  modport slave  (input sclk, copi, ncs);
endinterface

// File: rtl/sync_edge.sv
// sync_edge: multi-flop pin synchronizer with rise/fall detection on the synchronized level
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic [STAGES:0]   r_vld;
  logic              r_prev;
  logic              w_q;
  // Edges stay masked until the chain and r_prev hold real pin samples, so a pin
  // that differs from RST_VAL at reset release never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
      r_vld  <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
      r_vld  <= {r_vld[STAGES-1:0], 1'b1};
    end
  end
  assign w_q    = r_sync[STAGES-1];
  assign o_rise = r_vld[STAGES] & w_q & ~r_prev;
  assign o_fall = r_vld[STAGES] & ~w_q & r_prev;
endmodule

// File: rtl/spi_pwm_cfg_ctrl.sv
// spi_pwm_cfg_ctrl: SPI-slave write-only config port committing 16-bit frames into PWM registers
module spi_pwm_cfg_ctrl #(
  parameter int NUM_REGS    = pwm_cfg_pkg::NUM_REGS,
  parameter int ADDR_W      = pwm_cfg_pkg::ADDR_W,
  parameter int DATA_W      = pwm_cfg_pkg::DATA_W,
  parameter int SYNC_STAGES = pwm_cfg_pkg::SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_pwm_cfg_ctrl_if.slave    spi,
  output logic [DATA_W-1:0]    en_reg_out_7_0,
  output logic [DATA_W-1:0]    en_reg_out_15_8,
  output logic [DATA_W-1:0]    en_reg_pwm_7_0,
  output logic [DATA_W-1:0]    en_reg_pwm_15_8,
  output logic [DATA_W-1:0]    pwm_duty_cycle,
  output logic                 cfg_wr_pulse,
  output logic                 cfg_err_pulse
);
  import pwm_cfg_pkg::*;
  localparam int FW = 1 + ADDR_W + DATA_W;
  localparam int AW = $clog2(NUM_REGS);
  logic                             w_sclk_rise, w_sclk_fall_unused;
  logic                             w_ncs_rise, w_ncs_fall;
  logic                             w_copi;
  logic [SYNC_STAGES-1:0]           r_copi_sync;
  state_t                           r_state;
  logic [FW-1:0]                    r_shift;
  logic [4:0]                       r_cnt;
  logic [NUM_REGS-1:0][DATA_W-1:0]  r_regs;
  logic                             r_wr, r_err;
  logic                             w_full, w_write, w_commit, w_drop;
  logic [ADDR_W-1:0]                w_addr;
  logic [DATA_W-1:0]                w_data;
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .i_d(spi.sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall_unused)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
    .clk(clk), .rst(rst), .i_d(spi.ncs), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
  );
  // copi goes through the same depth as sclk so each bit lines up with its clock edge
  always_ff @(posedge clk) begin
    if (rst) r_copi_sync <= '0;
    else     r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], spi.copi};
  end
  assign w_copi   = r_copi_sync[SYNC_STAGES-1];
  assign w_full   = r_cnt == 5'(FRAME_BITS);
  assign w_write  = r_shift[FW-1];
  assign w_addr   = r_shift[FW-2 -: ADDR_W];
  assign w_data   = r_shift[DATA_W-1:0];
  assign w_commit = w_full & w_write & (w_addr < ADDR_W'(NUM_REGS));
  // complete read frames are dropped without flagging an error
  assign w_drop   = ~w_commit & ~(w_full & ~w_write);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_regs  <= '0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_wr  <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: if (w_ncs_fall) begin
          r_state <= SHIFT;
          r_shift <= '0;
          r_cnt   <= '0;
        end
        SHIFT: begin
          if (w_sclk_rise) begin
            r_shift <= {r_shift[FW-2:0], w_copi};
            r_cnt   <= (r_cnt == 5'(FRAME_BITS + 1)) ? r_cnt : r_cnt + 5'd1;
          end
          if (w_ncs_rise) r_state <= COMMIT;
        end
        COMMIT: begin
          r_state <= IDLE;
          r_wr    <= w_commit;
          r_err   <= w_drop;
          if (w_commit) r_regs[w_addr[AW-1:0]] <= w_data;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign en_reg_out_7_0  = r_regs[AW'(ADDR_EN_OUT_7_0)];
  assign en_reg_out_15_8 = r_regs[AW'(ADDR_EN_OUT_15_8)];
  assign en_reg_pwm_7_0  = r_regs[AW'(ADDR_EN_PWM_7_0)];
  assign en_reg_pwm_15_8 = r_regs[AW'(ADDR_EN_PWM_15_8)];
  assign pwm_duty_cycle  = r_regs[AW'(ADDR_PWM_DUTY)];
  assign cfg_wr_pulse    = r_wr;
  assign cfg_err_pulse   = r_err;
endmodule

// File: tb/tb_spi_pwm_cfg_ctrl.sv
// tb_spi_pwm_cfg_ctrl: directed SPI frames with a queue-based scoreboard on the commit/error pulses
module tb_spi_pwm_cfg_ctrl;
  localparam int H = 4;
  typedef struct {
    logic        wr;
    logic [39:0] regs;
    int          cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic cfg_wr_pulse, cfg_err_pulse;
  logic [39:0] w_regs;
  logic [7:0] m [5];
  exp_t q [$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  spi_pwm_cfg_ctrl_if spi_if ();
  spi_pwm_cfg_ctrl dut (
    .clk(clk), .rst(rst), .spi(spi_if.slave),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .cfg_wr_pulse(cfg_wr_pulse), .cfg_err_pulse(cfg_err_pulse)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign w_regs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  function automatic logic [39:0] snap();
    return {m[4], m[3], m[2], m[1], m[0]};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_if.copi = v[i];
      tick(H);
      spi_if.sclk = 1'b1;
      tick(H);
      spi_if.sclk = 1'b0;
    end
  endtask
  // kind: 0 = no pulse expected, 1 = commit, 2 = error
  task automatic frame(input logic [31:0] v, input int n, input int kind, input int gap);
    spi_if.ncs = 1'b0;
    tick(H);
    shift_bits(v, n);
    tick(H);
    spi_if.ncs = 1'b1;
    if (kind == 1) m[int'(v[10:8])] = v[7:0];
    if (kind != 0) q.push_back('{wr: (kind == 1), regs: snap(), cyc: cyc + 4});
    tick(gap);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cfg_wr_pulse || cfg_err_pulse) begin
        if (q.size() == 0) chk("pending_expectation", 64'd0, 64'd1);
        else begin
          e = q.pop_front();
          chk("pulse_kind", {62'd0, cfg_wr_pulse, cfg_err_pulse}, {62'd0, e.wr, ~e.wr});
          chk("regs_at_pulse", 64'(w_regs), 64'(e.regs));
          chk("pulse_latency", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    rst = 1'b1;
    spi_if.sclk = 1'b0;
    spi_if.copi = 1'b0;
    spi_if.ncs  = 1'b1;
    tick(3);
    chk("reset_regs", 64'(w_regs), 64'h0);
    chk("reset_pulses", {62'd0, cfg_wr_pulse, cfg_err_pulse}, 64'd0);
    rst = 1'b0;
    tick(6);
    chk("post_reset_pulses", {62'd0, cfg_wr_pulse, cfg_err_pulse}, 64'd0);
    frame(32'h80F0, 16, 1, 10);
    chk("t2_out_7_0", 64'(en_reg_out_7_0), 64'hF0);
    chk("t2_regs", 64'(w_regs), 64'h00_00_00_00_F0);
    frame(32'h8480, 16, 1, 2);
    frame(32'h84FF, 16, 1, 10);
    chk("t3_duty", 64'(pwm_duty_cycle), 64'hFF);
    chk("t3_regs", 64'(w_regs), 64'hFF_00_00_00_F0);
    frame(32'h85AA, 16, 2, 10);
    frame(32'h0011, 16, 0, 10);
    chk("t4_regs", 64'(w_regs), 64'hFF_00_00_00_F0);
    chk("t4_queue_drained", 64'(q.size()), 64'd0);
    frame(32'h40D5, 15, 2, 10);
    frame(32'h10356, 17, 2, 10);
    chk("t5_out_15_8", 64'(en_reg_out_15_8), 64'h00);
    chk("t5_regs", 64'(w_regs), 64'hFF_00_00_00_F0);
    spi_if.ncs = 1'b0;
    tick(H);
    shift_bits(32'h83, 8);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    chk("t6_regs_in_reset", 64'(w_regs), 64'h0);
    shift_bits(32'hFF, 8);
    tick(H);
    spi_if.ncs = 1'b1;
    tick(10);
    chk("t6_pwm_15_8_aborted", 64'(en_reg_pwm_15_8), 64'h00);
    chk("t6_queue_drained", 64'(q.size()), 64'd0);
    frame(32'h83FF, 16, 1, 10);
    chk("t6_pwm_15_8", 64'(en_reg_pwm_15_8), 64'hFF);
    chk("t6_regs", 64'(w_regs), 64'h00_FF_00_00_00);
    tick(10);
    chk("final_queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
